// File: rtl/mux_data_arb_8b.sv
// Two-channel round-robin arbiter feeding mux_data_8b: one-entry holding register per
// channel, grant held stable until the consumer accepts the selected word.
module mux_data_arb_8b (
  input  logic       clk,
  input  logic       rst,
  input  logic       in0_valid,
  input  logic [7:0] in0_data,
  output logic       in0_ready,
  input  logic       in1_valid,
  input  logic [7:0] in1_data,
  output logic       in1_ready,
  output logic [7:0] mux_in0,
  output logic [7:0] mux_in1,
  output logic       sel,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state, state_n;
  logic [7:0] hold0, hold1;
  logic       full0, full1, full0_n, full1_n;
  logic       sel_n, last, last_n;
  logic       load0, load1, xfer, other_full;

  assign in0_ready  = !full0;
  assign in1_ready  = !full1;
  assign mux_in0    = hold0;
  assign mux_in1    = hold1;
  assign out_valid  = (state == GRANT);
  assign load0      = in0_valid && !full0;
  assign load1      = in1_valid && !full1;
  assign xfer       = out_valid && out_ready;
  // Back-to-back check uses the pre-edge flag, so a word landing on the transfer edge waits for IDLE.
  assign other_full = sel ? full0 : full1;

  always_comb begin
    state_n = state;
    sel_n   = sel;
    last_n  = last;
    full0_n = full0;
    full1_n = full1;
    if (xfer) begin
      last_n = sel;
      if (sel) full1_n = 1'b0;
      else     full0_n = 1'b0;
    end
    if (load0) full0_n = 1'b1;
    if (load1) full1_n = 1'b1;
    case (state)
      IDLE: begin
        if (full0 || full1) begin
          state_n = GRANT;
          sel_n   = (full0 && full1) ? !last : full1;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (other_full) sel_n   = !sel;
          else            state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      full0 <= 1'b0;
      full1 <= 1'b0;
      hold0 <= 8'h00;
      hold1 <= 8'h00;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      last  <= last_n;
      full0 <= full0_n;
      full1 <= full1_n;
      if (load0) hold0 <= in0_data;
      if (load1) hold1 <= in1_data;
    end
  end

endmodule

// File: tb/tb_mux_data_arb_8b.sv
// Directed bench for mux_data_arb_8b; a monitor logs every accepted word for
// ordering and duplication checks.
module tb_mux_data_arb_8b;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in1_valid, in0_ready, in1_ready;
  logic [7:0] in0_data, in1_data, mux_in0, mux_in1;
  logic       sel, out_valid, out_ready;

  int         test_count = 0;
  int         fail_count = 0;
  int         xfer_count = 0;
  logic       log_sel[$];
  logic [7:0] log_data[$];
  int         base;

  mux_data_arb_8b dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .mux_in0   (mux_in0),
    .mux_in1   (mux_in1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Model of the downstream mux_data_8b plus consumer: log each accepted word.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      xfer_count++;
      log_sel.push_back(sel);
      log_data.push_back(sel ? mux_in1 : mux_in0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1,
                                input logic ordy);
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = ordy;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    test_count++;
    assert (obs === exp)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mux_out();
    return sel ? mux_in1 : mux_in0;
  endfunction

  initial begin
    // Reset with both valids high: nothing may be captured.
    rst = 1'b1;
    apply_stimulus(1'b1, 8'h12, 1'b1, 8'h34, 1'b1);
    tick();
    tick();
    check_output("rst_out_valid", {7'b0, out_valid}, 8'h00);
    check_output("rst_in0_ready", {7'b0, in0_ready}, 8'h01);
    check_output("rst_in1_ready", {7'b0, in1_ready}, 8'h01);
    check_output("rst_sel", {7'b0, sel}, 8'h00);
    check_output("rst_mux_in0", mux_in0, 8'h00);
    check_output("rst_mux_in1", mux_in1, 8'h00);
    rst = 1'b0;
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();

    // First tie after reset: ch0 wins, then ch1 back-to-back.
    apply_stimulus(1'b1, 8'hF0, 1'b1, 8'h35, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check_output("tie1_load_valid", {7'b0, out_valid}, 8'h00);
    check_output("tie1_in0_ready", {7'b0, in0_ready}, 8'h00);
    check_output("tie1_in1_ready", {7'b0, in1_ready}, 8'h00);
    tick();
    check_output("tie1_g0_valid", {7'b0, out_valid}, 8'h01);
    check_output("tie1_g0_sel", {7'b0, sel}, 8'h00);
    check_output("tie1_g0_data", mux_out(), 8'hF0);
    tick();
    check_output("tie1_g1_valid", {7'b0, out_valid}, 8'h01);
    check_output("tie1_g1_sel", {7'b0, sel}, 8'h01);
    check_output("tie1_g1_data", mux_out(), 8'h35);
    check_output("tie1_in0_free", {7'b0, in0_ready}, 8'h01);
    tick();
    check_output("tie1_idle", {7'b0, out_valid}, 8'h00);
    check_output("tie1_in1_free", {7'b0, in1_ready}, 8'h01);
    check_output("tie1_xfers", xfer_count[7:0], 8'd2);

    // Single channel: accept, grant, transfer.
    apply_stimulus(1'b1, 8'h4F, 1'b0, 8'h00, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check_output("single_load_valid", {7'b0, out_valid}, 8'h00);
    check_output("single_in0_busy", {7'b0, in0_ready}, 8'h00);
    tick();
    check_output("single_valid", {7'b0, out_valid}, 8'h01);
    check_output("single_sel", {7'b0, sel}, 8'h00);
    check_output("single_mux_in0", mux_in0, 8'h4F);
    tick();
    check_output("single_done", {7'b0, out_valid}, 8'h00);
    check_output("single_in0_free", {7'b0, in0_ready}, 8'h01);
    check_output("single_xfers", xfer_count[7:0], 8'd3);

    // Tie after ch0 was served last: ch1 wins now.
    apply_stimulus(1'b1, 8'hF0, 1'b1, 8'h35, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    check_output("tie2_g0_sel", {7'b0, sel}, 8'h01);
    check_output("tie2_g0_data", mux_out(), 8'h35);
    tick();
    check_output("tie2_g1_sel", {7'b0, sel}, 8'h00);
    check_output("tie2_g1_data", mux_out(), 8'hF0);
    tick();
    check_output("tie2_idle", {7'b0, out_valid}, 8'h00);

    // Backpressure on a ch1 grant; a new ch1 offer must be ignored while full.
    apply_stimulus(1'b0, 8'h00, 1'b1, 8'hAA, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
    tick();
    base = xfer_count;
    for (int i = 0; i < 5; i++) begin
      check_output("bp_valid", {7'b0, out_valid}, 8'h01);
      check_output("bp_sel", {7'b0, sel}, 8'h01);
      check_output("bp_mux_in1", mux_in1, 8'hAA);
      check_output("bp_in1_ready", {7'b0, in1_ready}, 8'h00);
      if (i < 4) tick();
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check_output("bp_done_valid", {7'b0, out_valid}, 8'h00);
    check_output("bp_in1_free", {7'b0, in1_ready}, 8'h01);
    tick();
    check_output("bp_one_xfer", 8'(xfer_count - base), 8'd1);
    check_output("bp_word", log_data[log_data.size() - 1], 8'hAA);

    // Mixed traffic: ch0 sends 25 then 1, ch1 sends 0.
    log_sel.delete();
    log_data.delete();
    apply_stimulus(1'b1, 8'd25, 1'b1, 8'd0, 1'b1);
    tick();
    apply_stimulus(1'b1, 8'd1, 1'b0, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check_output("mix_bubble", {7'b0, out_valid}, 8'h00);
    tick();
    tick();
    tick();
    check_output("mix_count", 8'(log_data.size()), 8'd3);
    if (log_data.size() == 3) begin
      check_output("mix_sel0", {7'b0, log_sel[0]}, 8'h00);
      check_output("mix_data0", log_data[0], 8'd25);
      check_output("mix_sel1", {7'b0, log_sel[1]}, 8'h01);
      check_output("mix_data1", log_data[1], 8'd0);
      check_output("mix_sel2", {7'b0, log_sel[2]}, 8'h00);
      check_output("mix_data2", log_data[2], 8'd1);
    end

    // Mid-operation reset under backpressure with both channels full.
    apply_stimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    check_output("mrst_pre_valid", {7'b0, out_valid}, 8'h01);
    base = xfer_count;
    rst = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    rst = 1'b0;
    check_output("mrst_valid", {7'b0, out_valid}, 8'h00);
    check_output("mrst_in0_ready", {7'b0, in0_ready}, 8'h01);
    check_output("mrst_in1_ready", {7'b0, in1_ready}, 8'h01);
    check_output("mrst_sel", {7'b0, sel}, 8'h00);
    check_output("mrst_mux_in1", mux_in1, 8'h00);
    check_output("mrst_no_xfer", 8'(xfer_count - base), 8'd0);
    // A tie right after reset must go to ch0 first again.
    apply_stimulus(1'b1, 8'h77, 1'b1, 8'h66, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    check_output("mrst_g0_sel", {7'b0, sel}, 8'h00);
    check_output("mrst_g0_data", mux_out(), 8'h77);
    tick();
    check_output("mrst_g1_sel", {7'b0, sel}, 8'h01);
    check_output("mrst_g1_data", mux_out(), 8'h66);
    tick();
    check_output("mrst_idle", {7'b0, out_valid}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
